// File: rtl/fxp_sat_accumulator.sv
// Saturating accumulate-and-dump stage for signed Q(INT.FRAC) samples.
// Sums up to ACC_LEN accepted samples, or fewer if flushed, and emits one result.
// The result carries sticky overflow/underflow flags and holds until it is taken downstream.
module fxp_sat_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 14,
    parameter int INT_WIDTH  = 2,
    parameter int ACC_LEN    = 8,
    parameter int CNT_WIDTH  = $clog2(ACC_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ovf,
    input  logic                  in_unf,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ovf,
    output logic                  out_unf,
    output logic [CNT_WIDTH-1:0]  out_count
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // One guard bit is enough: the sum of two DATA_WIDTH values fits in DATA_WIDTH+1.
    // Returns {pos_sat, neg_sat, result}.
    function automatic logic [DATA_WIDTH+1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] sum;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            if (sum[DATA_WIDTH] == 1'b0) begin
                sat_add = {1'b1, 1'b0, SAT_MAX};
            end else begin
                sat_add = {1'b0, 1'b1, SAT_MIN};
            end
        end else begin
            sat_add = {1'b0, 1'b0, sum[DATA_WIDTH-1:0]};
        end
    endfunction

    state_t                  state_q,     state_d;
    logic [DATA_WIDTH-1:0]   acc_q,       acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q,       cnt_d;
    logic                    ovf_st_q,    ovf_st_d;
    logic                    unf_st_q,    unf_st_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                    out_ovf_q,   out_ovf_d;
    logic                    out_unf_q,   out_unf_d;
    logic [CNT_WIDTH-1:0]    out_count_q, out_count_d;

    logic                    accept_s;
    logic                    close_s;
    logic [CNT_WIDTH-1:0]    cnt_inc_s;
    logic [DATA_WIDTH+1:0]   add_s;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;
    assign out_count = out_count_q;

    // Handshake, saturating sum and block-close decision for the current cycle.
    always_comb begin
        accept_s  = in_valid && (state_q == ST_ACCUM);
        cnt_inc_s = cnt_q + CNT_WIDTH'(1);
        add_s     = sat_add(acc_q, in_data);
        if (state_q == ST_ACCUM) begin
            close_s = (accept_s && (cnt_inc_s == CNT_WIDTH'(ACC_LEN))) ||
                      (flush && (accept_s || (cnt_q != {CNT_WIDTH{1'b0}})));
        end else begin
            close_s = 1'b0;
        end
    end

    // Next-state and datapath updates for the ACCUM/HOLD controller.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_st_d    = ovf_st_q;
        unf_st_d    = unf_st_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        out_count_d = out_count_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d    = add_s[DATA_WIDTH-1:0];
                    cnt_d    = cnt_inc_s;
                    ovf_st_d = ovf_st_q | add_s[DATA_WIDTH+1] | in_ovf;
                    unf_st_d = unf_st_q | add_s[DATA_WIDTH]   | in_unf;
                end else begin
                    acc_d = acc_q;
                end
                if (close_s) begin
                    state_d     = ST_HOLD;
                    out_data_d  = acc_d;
                    out_ovf_d   = ovf_st_d;
                    out_unf_d   = unf_st_d;
                    out_count_d = cnt_d;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    // Result taken: start a fresh block, leave the last result visible.
                    state_d  = ST_ACCUM;
                    acc_d    = {DATA_WIDTH{1'b0}};
                    cnt_d    = {CNT_WIDTH{1'b0}};
                    ovf_st_d = 1'b0;
                    unf_st_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers; async reset discards any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {DATA_WIDTH{1'b0}};
            cnt_q       <= {CNT_WIDTH{1'b0}};
            ovf_st_q    <= 1'b0;
            unf_st_q    <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            out_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_st_q    <= ovf_st_d;
            unf_st_q    <= unf_st_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_fxp_sat_accumulator.sv
// Self-checking bench for fxp_sat_accumulator: expected block results are queued
// as stimulus is driven and compared when the DUT presents a result.
module tb_fxp_sat_accumulator;

    localparam int DW  = 16;
    localparam int CW  = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          o;
        logic          u;
        logic [CW-1:0] c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_ovf, in_unf, flush;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_ovf, out_unf;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    fxp_sat_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ovf(in_ovf), .in_unf(in_unf), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result taken downstream must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got data=%h ovf=%b unf=%b cnt=%0d, expected no result",
                         out_data, out_ovf, out_unf, out_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_data, out_ovf, out_unf, out_count} !== {e.d, e.o, e.u, e.c}) begin
                    n_err++;
                    $display("FAIL sb_result: got data=%h ovf=%b unf=%b cnt=%0d, expected data=%h ovf=%b unf=%b cnt=%0d",
                             out_data, out_ovf, out_unf, out_count, e.d, e.o, e.u, e.c);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [DW-1:0] d, input logic o, input logic u, input int c);
        exp_t e;
        e.d = d; e.o = o; e.u = u; e.c = CW'(c);
        return e;
    endfunction

    // Present one sample and hold it until the DUT accepts it.
    task automatic send(input logic [DW-1:0] d, input logic ov, input logic un, input logic fl);
        int w;
        in_valid = 1'b1; in_data = d; in_ovf = ov; in_unf = un; flush = fl;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; in_ovf = 1'b0; in_unf = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            w++;
            @(negedge clk);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; in_unf = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        n_vec++;
        if ({out_valid, out_data, out_ovf, out_unf, out_count, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h o=%b u=%b c=%0d rdy=%b, expected 0/0000/0/0/0/1",
                     out_valid, out_data, out_ovf, out_unf, out_count, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_block();
        sb.push_back(mk(16'h4000, 1'b0, 1'b0, 8));
        for (int i = 0; i < 8; i++) send(16'h0800, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL latency: got out_valid=%b in_ready=%b, expected 1 0", out_valid, in_ready);
        end
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bubble_release: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_saturation();
        sb.push_back(mk(16'h5FFF, 1'b1, 1'b0, 3));
        send(16'h6000, 1'b0, 1'b0, 1'b0);
        send(16'h6000, 1'b0, 1'b0, 1'b0);
        send(16'hE000, 1'b0, 1'b0, 1'b1);
        drain();
        sb.push_back(mk(16'h8000, 1'b0, 1'b1, 2));
        send(16'hA000, 1'b0, 1'b0, 1'b0);
        send(16'hA000, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drain();
    endtask

    task automatic test_flag_passthrough();
        sb.push_back(mk(16'h0001, 1'b1, 1'b0, 8));
        send(16'h0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
        sb.push_back(mk(16'hFFFF, 1'b0, 1'b1, 1));
        send(16'hFFFF, 1'b0, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        repeat (3) @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_idle: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b0;
        sb.push_back(mk(16'h0800, 1'b0, 1'b0, 8));
        for (int i = 0; i < 8; i++) send(16'h0100, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 16'h0800, 4'd8}) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got v=%b rdy=%b d=%h c=%0d, expected 1 0 0800 8",
                         i, out_valid, in_ready, out_data, out_count);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb.push_back(mk(16'h0200, 1'b0, 1'b0, 8));
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        n_vec++;
        if (w != 1) begin
            n_err++;
            $display("FAIL held_accept: got wait=%0d cycles, expected 1", w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) send(16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_midblock_reset();
        for (int i = 0; i < 3; i++) send(16'h1000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, out_data, out_ovf, out_unf, out_count} !== {1'b0, 16'h0000, 1'b0, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL midblock_reset: got v=%b d=%h o=%b u=%b c=%0d, expected all 0",
                     out_valid, out_data, out_ovf, out_unf, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back(mk(16'h2000, 1'b0, 1'b0, 8));
        for (int i = 0; i < 8; i++) send(16'h0400, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_random_blocks();
        for (int b = 0; b < 6; b++) begin
            int            len, a;
            logic          o, u;
            logic [DW-1:0] d[8];
            logic          fo[8];
            len = $urandom_range(1, 8);
            a = 0; o = 1'b0; u = 1'b0;
            for (int i = 0; i < len; i++) begin
                d[i]  = DW'($urandom_range(0, 65535));
                fo[i] = ($urandom_range(0, 9) == 0);
                a = a + int'($signed(d[i]));
                if (a > 32767) begin a = 32767; o = 1'b1; end
                else if (a < -32768) begin a = -32768; u = 1'b1; end
                else begin a = a; end
                o = o | fo[i];
            end
            sb.push_back(mk(DW'(a), o, u, len));
            for (int i = 0; i < len; i++)
                send(d[i], fo[i], 1'b0, (i == len - 1) && (len < 8));
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_saturation();
        test_flag_passthrough();
        test_flush_idle();
        test_backpressure();
        test_midblock_reset();
        test_random_blocks();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
